// File: rtl/lcd_spi_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the LCD SPI transmit path. Provides
//               the character codes that make up the clear-screen prefix,
//               the default message length, the state encoding used by the
//               streamer and its byte shifter, and a counter-width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam logic [7:0] LCD_ESC    = 8'h1B;
  localparam logic [7:0] LCD_LBRACK = 8'h5B;
  localparam logic [7:0] LCD_CLR    = 8'h6A;
  localparam logic [7:0] LCD_NULL   = 8'h00;

  localparam int LCD_MSG_BYTES = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Width of a counter holding 0..n-1; never narrower than one bit so a
  // divisor or gap of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_spi_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_streamer_if
// Description : Bundle between the display FSM, the SPI streamer and the
//               LCD pins.
// Ports       : master - drives begin_transmission/data_in, observes the rest
//               slave  - the streamer: consumes the request, drives
//                        sclk/mosi/ss_n/busy/end_transmission
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_spi_streamer_if
  import lcd_pkg::*;
#(
  parameter int MSG_BYTES = LCD_MSG_BYTES
);

  logic                   begin_transmission;
  logic [8*MSG_BYTES-1:0] data_in;
  logic                   sclk;
  logic                   mosi;
  logic                   ss_n;
  logic                   busy;
  logic                   end_transmission;

  modport master (
    output begin_transmission,
    output data_in,
    input  sclk,
    input  mosi,
    input  ss_n,
    input  busy,
    input  end_transmission
  );

  modport slave (
    input  begin_transmission,
    input  data_in,
    output sclk,
    output mosi,
    output ss_n,
    output busy,
    output end_transmission
  );

endinterface
`default_nettype wire

// File: rtl/lcd_spi_streamer_spi_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_tx
// Description : Shifts one byte out MSB first in SPI mode 0. A load pulse
//               presents bit 7 on mosi immediately; each bit then spends
//               CLK_DIV cycles with sclk low followed by CLK_DIV cycles with
//               sclk high. done is high during the final cycle of the last
//               high phase so the caller can move on at that same edge.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               load         - start shifting byte_in (honoured when idle)
//               byte_in      - byte to send
//               sclk, mosi   - SPI clock / data, both registered
//               done         - last cycle of the byte
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       done
);

  localparam int                 DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t             phase;
  logic [7:0]         shreg;
  logic [2:0]         bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               sclk_reg;
  logic               div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign done    = (phase == ST_BIT_HI) && div_end && (bit_cnt == 3'd0);

  // mosi is the top of the shift register; zeros shift in behind the data,
  // so after the eighth shift the line returns to 0 without extra logic.
  assign mosi = shreg[7];
  assign sclk = sclk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= ST_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      div_cnt  <= '0;
      sclk_reg <= 1'b0;
    end else begin
      case (phase)
        ST_IDLE: begin
          sclk_reg <= 1'b0;
          if (load) begin
            shreg   <= byte_in;
            bit_cnt <= 3'd7;
            div_cnt <= '0;
            phase   <= ST_BIT_LO;
          end
        end
        ST_BIT_LO: begin
          if (div_end) begin
            div_cnt  <= '0;
            sclk_reg <= 1'b1;
            phase    <= ST_BIT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_BIT_HI: begin
          if (div_end) begin
            div_cnt  <= '0;
            sclk_reg <= 1'b0;
            shreg    <= {shreg[6:0], 1'b0};
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              phase   <= ST_BIT_LO;
            end else begin
              phase <= ST_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          phase    <= ST_IDLE;
          sclk_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_streamer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_streamer
// Description : Transmit end of the display path. Latches a NULL-terminated
//               message on a begin request, sends it byte by byte over SPI
//               mode 0 with an idle gap between bytes, then pulses
//               end_transmission for one cycle.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - lcd_spi_streamer_if.slave:
//                          begin_transmission, data_in (byte 0 in MSBs),
//                          sclk, mosi, ss_n, busy, end_transmission
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_streamer
  import lcd_pkg::*;
#(
  parameter int MSG_BYTES  = LCD_MSG_BYTES,
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 4000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_spi_streamer_if.slave     bus
);

  localparam int               IDX_W    = cnt_width(MSG_BYTES + 1);
  localparam int               GAP_W    = cnt_width(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(MSG_BYTES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                 state;
  logic [8*MSG_BYTES-1:0] msg;
  logic [IDX_W-1:0]       byte_idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   ss_n_reg;
  logic                   busy_reg;
  logic                   end_reg;

  logic [7:0]             cur_byte;
  logic                   msg_end;
  logic                   load;
  logic                   byte_done;
  logic                   tx_sclk;
  logic                   tx_mosi;

  // The latched message is shifted up by a byte after each send, so the
  // current byte is always the top byte of the register.
  assign cur_byte = msg[8*MSG_BYTES-1 -: 8];
  assign msg_end  = (cur_byte == LCD_NULL) || (byte_idx == IDX_END);

  // Combinational so the shifter puts bit 7 on mosi at the same edge that
  // leaves LOAD, keeping LOAD to a single cycle.
  assign load = (state == ST_LOAD) && !msg_end;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_byte_tx (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .byte_in (cur_byte),
    .sclk    (tx_sclk),
    .mosi    (tx_mosi),
    .done    (byte_done)
  );

  assign bus.sclk             = tx_sclk;
  assign bus.mosi             = tx_mosi;
  assign bus.ss_n             = ss_n_reg;
  assign bus.busy             = busy_reg;
  assign bus.end_transmission = end_reg;

  // ST_BIT_LO here means "a byte is in flight"; the individual low/high
  // bit phases are sequenced inside spi_byte_tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      msg      <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      ss_n_reg <= 1'b1;
      busy_reg <= 1'b0;
      end_reg  <= 1'b0;
    end else begin
      end_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.begin_transmission) begin
            msg      <= bus.data_in;
            byte_idx <= '0;
            busy_reg <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (msg_end) begin
            ss_n_reg <= 1'b1;
            end_reg  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            ss_n_reg <= 1'b0;
            state    <= ST_BIT_LO;
          end
        end
        ST_BIT_LO: begin
          if (byte_done) begin
            byte_idx <= byte_idx + IDX_W'(1);
            msg      <= msg << 8;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          busy_reg <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          ss_n_reg <= 1'b1;
          busy_reg <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_streamer
// Description : Self-checking bench for lcd_spi_streamer with CLK_DIV=2,
//               GAP_CYCLES=4, MSG_BYTES=19. Expected bytes are queued when a
//               message is started and popped as bytes are captured on sclk
//               rising edges.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_streamer;
  import lcd_pkg::*;

  localparam int MB       = 19;
  localparam int DIV      = 2;
  localparam int GAP      = 4;
  localparam int PER_BYTE = 16*DIV + GAP + 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   ec0 = 0;
  int   end_count = 0;
  int   ss_low_cycles = 0;

  logic [7:0] exp_q[$];

  // monitor state
  logic       prev_sclk;
  logic       prev_mosi;
  int         run;
  int         mon_nb;
  int         mon_nbits;
  logic [7:0] mon_sh;

  lcd_spi_streamer_if #(.MSG_BYTES(MB)) bus ();

  lcd_spi_streamer #(
    .MSG_BYTES  (MB),
    .CLK_DIV    (DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Byte capture on sclk rising edges, bit timing and idle-line checks.
  always @(negedge clk) begin
    if (rst) begin
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      run       = 0;
      mon_nb    = 0;
      mon_nbits = 0;
      mon_sh    = 8'h00;
    end else begin
      if (bus.ss_n) begin
        check("idle_sclk", bus.sclk, 0);
        check("idle_mosi", bus.mosi, 0);
        run       = 0;
        mon_nb    = 0;
        mon_nbits = 0;
      end else begin
        ss_low_cycles++;
        if (bus.sclk != prev_sclk) begin
          if (bus.sclk) begin
            check("low_run", run, (mon_nbits == 0 && mon_nb > 0) ? (GAP + 1 + DIV) : DIV);
            mon_sh = {mon_sh[6:0], bus.mosi};
            mon_nbits++;
            if (mon_nbits == 8) begin
              check("rx_queue_has_entry", (exp_q.size() > 0), 1);
              if (exp_q.size() > 0) check("rx_byte", mon_sh, exp_q.pop_front());
              mon_nb++;
              mon_nbits = 0;
            end
          end else begin
            check("high_run", run, DIV);
          end
          run = 1;
        end else begin
          run++;
        end
        if (bus.sclk) check("mosi_stable_high", bus.mosi, prev_mosi);
      end
      if (bus.end_transmission) end_count++;
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
    end
  end

  task automatic push_msg(input logic [8*MB-1:0] m, output int n);
    logic [7:0] b;
    n = 0;
    for (int i = 0; i < MB; i++) begin
      b = m[8*(MB-i)-1 -: 8];
      if (b == LCD_NULL) break;
      exp_q.push_back(b);
      n++;
    end
  endtask

  task automatic start_msg(input string tag, input logic [8*MB-1:0] m, output int n);
    ec0 = end_count;
    bus.data_in = m;
    push_msg(m, n);
    bus.begin_transmission = 1'b1;
    tick(1);
    bus.begin_transmission = 1'b0;
    t0 = cyc;
    check({tag, "_busy_after_begin"}, bus.busy, 1);
    check({tag, "_ss_n_in_load"}, bus.ss_n, 1);
  endtask

  task automatic wait_end(input string tag, input int nbytes);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick(1);
      if (bus.end_transmission) seen = 1'b1;
    end
    check({tag, "_end_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_end_latency"}, cyc - t0, 1 + PER_BYTE*nbytes);
      check({tag, "_busy_in_done"}, bus.busy, 1);
      check({tag, "_ss_n_in_done"}, bus.ss_n, 1);
    end
    tick(1);
    check({tag, "_end_single"}, bus.end_transmission, 0);
    check({tag, "_busy_low"}, bus.busy, 0);
    check({tag, "_end_count"}, end_count - ec0, 1);
    check({tag, "_all_bytes_sent"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [8*MB-1:0] m;
    int n;
    int ssl0;
    int ecr;
    bit hit;

    rst = 1'b1;
    bus.begin_transmission = 1'b0;
    bus.data_in = '0;
    tick(3);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_ss_n", bus.ss_n, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_end",  bus.end_transmission, 0);
    rst = 1'b0;
    tick(5);

    // 1) ESC [ j '1' '2' NULL
    m = {LCD_ESC, LCD_LBRACK, LCD_CLR, 8'h31, 8'h32, {14{8'h00}}};
    start_msg("m5", m, n);
    check("m5_nbytes", n, 5);
    tick(1);
    check("m5_ss_n_low", bus.ss_n, 0);
    check("m5_sclk_low", bus.sclk, 0);
    check("m5_first_bit", bus.mosi, 0);
    wait_end("m5", 5);
    tick(3);

    // 2) NULL first byte: nothing on the wire, end 1 cycle after LOAD
    ssl0 = ss_low_cycles;
    m = {8'h00, 8'h41, {17{8'h00}}};
    start_msg("null", m, n);
    wait_end("null", 0);
    check("null_no_ss_low", ss_low_cycles - ssl0, 0);
    tick(3);

    // 3) all 19 bytes non-NULL
    for (int i = 0; i < MB; i++) m[8*(MB-i)-1 -: 8] = 8'h41 + 8'(i);
    start_msg("full", m, n);
    check("full_nbytes", n, MB);
    wait_end("full", MB);
    tick(3);

    // 4) begin re-pulsed while busy with new data_in: ignored
    m = {LCD_ESC, LCD_LBRACK, LCD_CLR, 8'h48, 8'h49, {14{8'h00}}};
    start_msg("repulse", m, n);
    tick(60);
    bus.data_in = {MB{8'h55}};
    bus.begin_transmission = 1'b1;
    tick(1);
    bus.begin_transmission = 1'b0;
    check("repulse_still_busy", bus.busy, 1);
    bus.data_in = {MB{8'hA5}};
    wait_end("repulse", 5);
    ecr = end_count;
    tick(10);
    check("repulse_no_retrigger", bus.busy, 0);
    check("repulse_no_extra_end", end_count - ecr, 0);

    // 5) reset during bit 3 of byte 2, then a fresh send
    m = {LCD_ESC, LCD_LBRACK, LCD_CLR, 8'h41, 8'h42, 8'h43, {13{8'h00}}};
    start_msg("abort", m, n);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      tick(1);
      if (mon_nb == 2 && mon_nbits == 4) hit = 1'b1;
    end
    check("abort_reached_bit3", hit, 1);
    ecr = end_count;
    rst = 1'b1;
    tick(1);
    check("abort_sclk", bus.sclk, 0);
    check("abort_ss_n", bus.ss_n, 1);
    check("abort_mosi", bus.mosi, 0);
    check("abort_busy", bus.busy, 0);
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(10);
    check("abort_no_end", end_count - ecr, 0);
    start_msg("resend", m, n);
    check("resend_nbytes", n, 6);
    wait_end("resend", 6);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
